car_datapath: RTL
=================

Name: car_datapath

Overview:
Datapath partner of the race control FSM. Holds the car position and sprite pixel counter. Produces the car-sized pixel stream (x, y, colour) for the VGA adapter during car draw/erase. Applies move commands and reports completion, wall-hit and finish status back to the FSM.

Parameters:
SCREEN_W, 160, screen width in pixels
CAR_W, 8, sprite width
CAR_H, 8, sprite height
START_X, 76, car x loaded on start/reset
START_Y, 104, car y loaded on start/reset
STEP, 4, x change per left/right move
SPEED, 2, y decrease per forward move
LEFT_WALL, 40, lowest legal car x
RIGHT_WALL, 120, car x + CAR_W must not exceed this
FINISH_Y, 8, finish line; car_y <= FINISH_Y means finished
CAR_COLOUR, 3'b100, sprite colour where mask bit = 1
BG_COLOUR, 3'b000, track colour; used for erase and mask bit = 0
SPRITE_MASK, {64{1'b1}}, bit (row*CAR_W+col) selects car vs background pixel

Ports:
Clock  in  1  system clock
Reset  in  1  asynchronous, active-high reset
set_reset_signals  in  1  pulse: reload start position, clear HitWall and done flags
start_race  in  1  pulse: as set_reset_signals, also clears FinishedRace
draw_car  in  1  level: stream sprite pixels
draw_over_car  in  1  level: stream BG_COLOUR over the car footprint
move  in  1  pulse: apply one movement
forward, left, right  in  1 each  player keys, sampled on move
x_out  out  8  pixel x
y_out  out  7  pixel y
colour_out  out  3  pixel colour
DoneDrawCar  out  1  sticky: sprite draw complete
DoneDrawOverCar  out  1  sticky: erase complete
HitWall  out  1  car outside [LEFT_WALL, RIGHT_WALL]
FinishedRace  out  1  sticky: finish line reached
car_x  out  8  current car x
car_y  out  7  current car y

Behaviour:
- Reset (async, immediate): car_x=START_X, car_y=START_Y, counter=0, all flags 0. x_out=START_X, y_out=START_Y, colour_out=0.
- Pixel counter: 6 bits (CAR_W*CAR_H=64). col=cnt mod CAR_W, row=cnt div CAR_W.
- Pixel outputs are combinational from registered state: x_out=car_x+col, y_out=car_y+row.
- colour_out:
  - draw_over_car: BG_COLOUR.
  - draw_car: mask bit set gives CAR_COLOUR, clear gives BG_COLOUR.
  - Neither active: 0.
- Active draw = draw_car with !DoneDrawCar, or draw_over_car with !DoneDrawOverCar. Pixel cnt is presented in that cycle.
- Counter advance: next edge cnt+1. At cnt=63, cnt wraps to 0 and the matching Done flag sets; total 64 cycles, Done visible in cycle 65.
- Draw input low mid-stream: counter holds (pause). Counter clears to 0 when the active mode changes between car and over-car.
- DoneDrawCar stays high after draw_car drops. Cleared on the first edge with draw_over_car high, and on set_reset_signals or start_race.
- DoneDrawOverCar stays high after draw_over_car drops. Cleared on the first edge with draw_car high, and on set_reset_signals or start_race.
- draw_car and draw_over_car both high: draw_car wins.
- move (one edge), priority forward > left/right:
  - forward: car_y -= SPEED, saturating at 0.
  - left only: car_x -= STEP, saturating at 0.
  - right only: car_x += STEP, saturating at SCREEN_W-CAR_W.
  - left and right together, or no key: no change.
- HitWall: registered, recomputed from the post-move position on the move edge. Set when car_x < LEFT_WALL or car_x+CAR_W > RIGHT_WALL.
- FinishedRace: set on a move edge when new car_y <= FINISH_Y. Sticky; cleared only by start_race or Reset.
- set_reset_signals/start_race (one edge): position reload, counter=0. Both override a simultaneous move or draw.
- All additions are done one bit wider than the operand before saturation compare, so no wrap-around.

Test Plan:
- Reset asserted mid-stream at cnt=20 -> counter 0, car at (76,104), all flags 0 without waiting for a clock edge; release then draw_car -> first pixel (76,104).
- start_race, then draw_car held until DoneDrawCar -> 64 pixels, first (76,104), last (83,111), CAR_COLOUR; DoneDrawCar high in cycle 65 and stays high after draw_car drops.
- After the above, draw_over_car held -> DoneDrawCar clears next edge; 64 pixels of BG_COLOUR over the same footprint; DoneDrawOverCar high in cycle 65.
- 9 move pulses with right=1 -> car_x=112, HitWall=0; 10th pulse -> car_x=116, HitWall=1; set_reset_signals -> car_x=76, HitWall=0.
- 48 move pulses with forward=1 -> car_y=8, FinishedRace=1 after move 48 (0 after 47); set_reset_signals keeps it 1; start_race clears it.
- move with left=right=1, then move with forward+left -> position unchanged, then only car_y decreases by 2; draw_car dropped at cnt=30 for 5 cycles then reasserted -> stream resumes at cnt=30.

Source files
------------

// File: rtl/car_datapath.sv
// Car datapath for the race controller.
// Holds the car position and sprite pixel counter, streams car-sized pixels
// for drawing and erasing, and applies move commands with wall and finish status.
module car_datapath #(
  parameter int                         SCREEN_W    = 160,
  parameter int                         CAR_W       = 8,
  parameter int                         CAR_H       = 8,
  parameter int                         START_X     = 76,
  parameter int                         START_Y     = 104,
  parameter int                         STEP        = 4,
  parameter int                         SPEED       = 2,
  parameter int                         LEFT_WALL   = 40,
  parameter int                         RIGHT_WALL  = 120,
  parameter int                         FINISH_Y    = 8,
  parameter logic [2:0]                 CAR_COLOUR  = 3'b100,
  parameter logic [2:0]                 BG_COLOUR   = 3'b000,
  parameter logic [CAR_W*CAR_H-1:0]     SPRITE_MASK = '1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       set_reset_signals,
  input  logic       start_race,
  input  logic       draw_car,
  input  logic       draw_over_car,
  input  logic       move,
  input  logic       forward,
  input  logic       left,
  input  logic       right,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour_out,
  output logic       DoneDrawCar,
  output logic       DoneDrawOverCar,
  output logic       HitWall,
  output logic       FinishedRace,
  output logic [7:0] car_x,
  output logic [6:0] car_y
);

  localparam int               CNT_W   = $clog2(CAR_W * CAR_H);
  localparam logic [CNT_W-1:0] CW_C    = CNT_W'(CAR_W);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CAR_W * CAR_H - 1);
  localparam logic [7:0]       X0      = 8'(START_X);
  localparam logic [6:0]       Y0      = 7'(START_Y);
  localparam logic [7:0]       X_STEP  = 8'(STEP);
  localparam logic [6:0]       Y_SPD   = 7'(SPEED);
  localparam logic [7:0]       X_MAX   = 8'(SCREEN_W - CAR_W);
  localparam logic [8:0]       X_MAX9  = 9'(SCREEN_W - CAR_W);
  localparam logic [7:0]       LW      = 8'(LEFT_WALL);
  localparam logic [8:0]       RW9     = 9'(RIGHT_WALL);
  localparam logic [8:0]       CW9     = 9'(CAR_W);
  localparam logic [6:0]       FIN_Y   = 7'(FINISH_Y);

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
  } pos_t;

  logic [CNT_W-1:0] cnt, pix_cnt, col, row;
  logic             last_mode;   // 0: car, 1: over-car
  logic             srst;
  logic             eff_over, act_car, act_over, act, mode_chg;
  pos_t             nxt;
  logic [8:0]       x_plus;
  logic             hit_n;

  assign srst     = set_reset_signals | start_race;
  // draw_car has priority when both draw requests are high
  assign eff_over = draw_over_car & ~draw_car;
  assign act_car  = draw_car & ~DoneDrawCar;
  assign act_over = eff_over & ~DoneDrawOverCar;
  assign act      = act_car | act_over;
  // A switch between car and over-car streams restarts from pixel 0 immediately
  assign mode_chg = act & (act_over != last_mode);
  assign pix_cnt  = mode_chg ? '0 : cnt;
  assign col      = pix_cnt % CW_C;
  assign row      = pix_cnt / CW_C;
  assign x_out    = car_x + 8'(col);
  assign y_out    = car_y + 7'(row);

  // Pixel colour: sprite mask while drawing, background while erasing
  always_comb begin
    colour_out = 3'b000;
    if (draw_car)
      colour_out = SPRITE_MASK[pix_cnt] ? CAR_COLOUR : BG_COLOUR;
    else if (draw_over_car)
      colour_out = BG_COLOUR;
  end

  // Next car position for a move command (one bit wider before saturating)
  always_comb begin
    nxt.x  = car_x;
    nxt.y  = car_y;
    x_plus = {1'b0, car_x} + {1'b0, X_STEP};
    if (forward)
      nxt.y = (car_y < Y_SPD) ? 7'd0 : car_y - Y_SPD;
    else if (left && !right)
      nxt.x = (car_x < X_STEP) ? 8'd0 : car_x - X_STEP;
    else if (right && !left)
      nxt.x = (x_plus > X_MAX9) ? X_MAX : x_plus[7:0];
    hit_n = (nxt.x < LW) || (({1'b0, nxt.x} + CW9) > RW9);
  end

  // Car position, wall and finish status
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      car_x        <= X0;
      car_y        <= Y0;
      HitWall      <= 1'b0;
      FinishedRace <= 1'b0;
    end else if (srst) begin
      car_x   <= X0;
      car_y   <= Y0;
      HitWall <= 1'b0;
      if (start_race) FinishedRace <= 1'b0;
    end else if (move) begin
      car_x   <= nxt.x;
      car_y   <= nxt.y;
      HitWall <= hit_n;
      if (nxt.y <= FIN_Y) FinishedRace <= 1'b1;
    end
  end

  // Pixel counter and sticky draw-complete flags
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cnt             <= '0;
      last_mode       <= 1'b0;
      DoneDrawCar     <= 1'b0;
      DoneDrawOverCar <= 1'b0;
    end else if (srst) begin
      cnt             <= '0;
      DoneDrawCar     <= 1'b0;
      DoneDrawOverCar <= 1'b0;
    end else begin
      if (act) begin
        last_mode <= act_over;
        cnt       <= (pix_cnt == CNT_MAX) ? '0 : pix_cnt + 1'b1;
      end
      if (act_car && pix_cnt == CNT_MAX) DoneDrawCar <= 1'b1;
      else if (eff_over)                 DoneDrawCar <= 1'b0;
      if (act_over && pix_cnt == CNT_MAX) DoneDrawOverCar <= 1'b1;
      else if (draw_car)                  DoneDrawOverCar <= 1'b0;
    end
  end

endmodule
